alu_flag_unit: RTL and testbench



---
 rtl/alu_flag_unit.sv | 109 ++++++++++
 tb/tb_alu_flag_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_flag_unit.sv
// alu_flag_unit: evaluates ALU condition flags, queues writeback/branch
// results in a 2-entry FIFO, and tracks signed overflow events.
module alu_flag_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] alu_out,
  input  logic        alu_ofl,
  input  logic        alu_z,
  input  logic        alu_ltz,
  input  logic [2:0]  cond,
  input  logic        is_set,
  input  logic        is_branch,
  input  logic        chk_ofl,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        br_taken,
  input  logic        clr_ofl,
  output logic        ofl_sticky,
  output logic [7:0]  ofl_count
);

  logic [15:0] mem_data [0:1];
  logic        mem_taken [0:1];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;

  logic        ct;
  logic        push;
  logic        pop;
  logic        ofl_event;
  logic [15:0] ent_data;
  logic        ent_taken;

  // Condition select over the ALU flags.
  always_comb begin
    ct = 1'b0;
    unique case (cond)
      3'b000: ct = alu_z;
      3'b001: ct = ~alu_z;
      3'b010: ct = alu_ltz;
      3'b011: ct = ~alu_ltz;
      3'b100: ct = alu_ltz | alu_z;
      3'b101: ct = alu_ofl;
      3'b110: ct = 1'b1;
      3'b111: ct = 1'b0;
    endcase
  end

  assign in_ready  = rst_n & (count != 2'd2);
  assign res_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = res_valid & res_ready;
  assign ofl_event = push & chk_ofl & alu_ofl;

  assign ent_data  = is_set ? {15'b0, ct} : alu_out;
  assign ent_taken = is_branch & ct;

  assign res_data  = res_valid ? mem_data[rd_ptr] : 16'h0000;
  assign br_taken  = res_valid ? mem_taken[rd_ptr] : 1'b0;

  // FIFO pointers and occupancy; reset discards all entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage, written on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_data[0]  <= 16'h0000;
      mem_data[1]  <= 16'h0000;
      mem_taken[0] <= 1'b0;
      mem_taken[1] <= 1'b0;
    end else if (push) begin
      mem_data[wr_ptr]  <= ent_data;
      mem_taken[wr_ptr] <= ent_taken;
    end
  end

  // Sticky overflow flag and saturating event counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ofl_sticky <= 1'b0;
      ofl_count  <= 8'd0;
    end else if (clr_ofl) begin
      ofl_sticky <= ofl_event;
      ofl_count  <= ofl_event ? 8'd1 : 8'd0;
    end else if (ofl_event) begin
      ofl_sticky <= 1'b1;
      if (ofl_count != 8'hFF) ofl_count <= ofl_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_flag_unit.sv
// tb_alu_flag_unit: directed vectors with hand-computed expectations
// for alu_flag_unit.
module tb_alu_flag_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] alu_out;
  logic        alu_ofl;
  logic        alu_z;
  logic        alu_ltz;
  logic [2:0]  cond;
  logic        is_set;
  logic        is_branch;
  logic        chk_ofl;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        br_taken;
  logic        clr_ofl;
  logic        ofl_sticky;
  logic [7:0]  ofl_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_flag_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_out    (alu_out),
    .alu_ofl    (alu_ofl),
    .alu_z      (alu_z),
    .alu_ltz    (alu_ltz),
    .cond       (cond),
    .is_set     (is_set),
    .is_branch  (is_branch),
    .chk_ofl    (chk_ofl),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .br_taken   (br_taken),
    .clr_ofl    (clr_ofl),
    .ofl_sticky (ofl_sticky),
    .ofl_count  (ofl_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [15:0] d,
                       input logic o, input logic z,
                       input logic l, input logic [2:0] c,
                       input logic s, input logic b,
                       input logic k);
    in_valid  = v;
    alu_out   = d;
    alu_ofl   = o;
    alu_z     = z;
    alu_ltz   = l;
    cond      = c;
    is_set    = s;
    is_branch = b;
    chk_ofl   = k;
  endtask

  initial begin
    rst_n     = 1'b0;
    res_ready = 1'b0;
    clr_ofl   = 1'b0;
    drive(0, 16'h0, 0, 0, 0, 3'd0, 0, 0, 0);

    // reset
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_br_taken", br_taken, 0);
    chk("rst_sticky", ofl_sticky, 0);
    chk("rst_count", ofl_count, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", in_ready, 1);
    step();
    chk("idle_ready", in_ready, 1);
    chk("idle_valid", res_valid, 0);

    // set ops
    res_ready = 1'b1;
    drive(1, 16'h0000, 0, 1, 0, 3'b000, 1, 0, 0);
    step();
    chk("seq_valid", res_valid, 1);
    chk("seq_data", res_data, 16'h0001);
    drive(1, 16'h0000, 0, 0, 1, 3'b100, 1, 0, 0);
    step();
    chk("sle_data", res_data, 16'h0001);
    drive(1, 16'h0000, 0, 0, 1, 3'b011, 1, 0, 0);
    step();
    chk("sge_data", res_data, 16'h0000);
    chk("sge_valid", res_valid, 1);
    drive(0, 16'h0, 0, 0, 0, 3'd0, 0, 0, 0);
    step();
    chk("set_drain", res_valid, 0);

    // branch
    drive(1, 16'h1234, 0, 0, 0, 3'b001, 0, 1, 0);
    step();
    chk("bne_data", res_data, 16'h1234);
    chk("bne_taken", br_taken, 1);
    drive(1, 16'h1234, 0, 1, 0, 3'b001, 0, 1, 0);
    step();
    chk("bne_nt_data", res_data, 16'h1234);
    chk("bne_nt_taken", br_taken, 0);
    // set and branch together
    drive(1, 16'h5555, 0, 0, 0, 3'b110, 1, 1, 0);
    step();
    chk("both_data", res_data, 16'h0001);
    chk("both_taken", br_taken, 1);
    drive(0, 16'h0, 0, 0, 0, 3'd0, 0, 0, 0);
    step();
    chk("br_drain", res_valid, 0);
    chk("empty_taken", br_taken, 0);

    // backpressure
    res_ready = 1'b0;
    drive(1, 16'h0AAA, 0, 0, 0, 3'b111, 0, 1, 0);
    step();
    chk("bp_ready1", in_ready, 1);
    drive(1, 16'h0BBB, 0, 0, 0, 3'b110, 0, 1, 0);
    step();
    chk("bp_full", in_ready, 0);
    chk("bp_head_a", res_data, 16'h0AAA);
    chk("bp_head_a_tk", br_taken, 0);
    drive(1, 16'h0CCC, 0, 0, 0, 3'b110, 0, 0, 0);
    step();
    chk("bp_hold", res_data, 16'h0AAA);
    chk("bp_still_full", in_ready, 0);
    drive(0, 16'h0, 0, 0, 0, 3'd0, 0, 0, 0);
    res_ready = 1'b1;
    #1;
    chk("bp_no_bypass", in_ready, 0);
    step();
    chk("bp_head_b", res_data, 16'h0BBB);
    chk("bp_head_b_tk", br_taken, 1);
    chk("bp_ready_back", in_ready, 1);
    step();
    chk("bp_drained", res_valid, 0);

    // streaming push/pop at count 1
    drive(1, 16'd0, 0, 0, 0, 3'd0, 0, 0, 0);
    step();
    chk("st_head0", res_data, 0);
    for (int i = 1; i <= 10; i++) begin
      alu_out = 16'(i);
      step();
      chk("st_head", res_data, i);
      chk("st_ready", in_ready, 1);
    end
    drive(0, 16'h0, 0, 0, 0, 3'd0, 0, 0, 0);
    step();
    chk("st_drain", res_valid, 0);
    chk("ofl_untouched", ofl_count, 0);

    // overflow counting and saturation
    drive(1, 16'h7FFF, 1, 0, 0, 3'd0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step();
    chk("ofl_10", ofl_count, 10);
    chk("ofl_sticky", ofl_sticky, 1);
    for (int i = 0; i < 290; i++) step();
    chk("ofl_sat", ofl_count, 255);
    chk("ofl_sat_sticky", ofl_sticky, 1);
    clr_ofl = 1'b1;
    step();
    chk("clr_ev_count", ofl_count, 1);
    chk("clr_ev_sticky", ofl_sticky, 1);
    clr_ofl = 1'b0;
    chk_ofl = 1'b0;
    step();
    chk("nochk_count", ofl_count, 1);
    chk("nochk_sticky", ofl_sticky, 1);
    in_valid = 1'b0;
    chk_ofl  = 1'b1;
    step();
    chk("noacc_count", ofl_count, 1);
    clr_ofl = 1'b1;
    step();
    chk("clr_count", ofl_count, 0);
    chk("clr_sticky", ofl_sticky, 0);
    clr_ofl = 1'b0;

    // reset mid-operation
    res_ready = 1'b0;
    drive(1, 16'h0DDD, 0, 0, 0, 3'd0, 0, 0, 0);
    step();
    step();
    chk("mid_full", in_ready, 0);
    rst_n = 1'b0;
    in_valid = 1'b0;
    step();
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_data", res_data, 0);
    chk("mid_rst_ready", in_ready, 0);
    rst_n = 1'b1;
    step();
    chk("mid_after_ready", in_ready, 1);
    chk("mid_after_valid", res_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
